// File: rtl/inst_fetch_port_pkg.sv
// Shared types and constants for the instruction-fetch responder: fetch FSM
// encoding, instruction bus width and handshake/enable levels.
package inst_fetch_port_pkg;

    localparam int INST_W = 32;
    localparam int BYTE_W = 8;

    localparam logic RST_ENABLE      = 1'b0;
    localparam logic CHIP_ENABLE     = 1'b1;
    localparam logic MEM_REQ_ENABLE  = 1'b1;
    localparam logic MEM_REQ_DISABLE = 1'b0;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_BUSY = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_port.sv
// Instruction-fetch responder: assembles a little-endian 32-bit word from four
// acked byte beats, keeps it in a one-entry buffer and stalls ctrl on a miss.
module inst_fetch_port
    import inst_fetch_port_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  byte_t             mem_data_i,
    input  logic              mem_ack_i,
    output inst_t             inst_o,
    output logic              inst_valid_o,
    output logic              stallreq_o
);

    fetch_state_e      state;
    logic [1:0]        beat;
    logic              abort;
    logic              buf_valid;
    logic [ADDR_W-3:0] buf_tag;
    logic [ADDR_W-3:0] fetch_tag;
    logic [23:0]       shift;

    logic hit;
    logic start;
    logic kill;
    logic unused_pc_bits;

    // The low PC bits only select a byte within the word; fetches are word-aligned.
    assign unused_pc_bits = ^pc_i[1:0];

    assign hit   = (ce_i == CHIP_ENABLE) && buf_valid && (pc_i[ADDR_W-1:2] == buf_tag);
    assign start = (state == FETCH_IDLE) && (ce_i == CHIP_ENABLE) && !hit && !flush_i;
    assign kill  = abort || flush_i;

    assign inst_valid_o = hit && (state == FETCH_IDLE);

    // Held low during reset so ctrl sees the stall drop together with mem_req_o.
    assign stallreq_o = (rst != RST_ENABLE) && (start || (state == FETCH_BUSY));

    // NOTE: every register here uses non-blocking assignments so all state
    // updates within a cycle see the same pre-edge values.
    // NOTE: the instruction buffer is a single register, not a RAM, so it is
    // reset along with the rest of the state and inst_o is defined out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state      <= FETCH_IDLE;
            beat       <= 2'd0;
            abort      <= 1'b0;
            buf_valid  <= 1'b0;
            buf_tag    <= '0;
            fetch_tag  <= '0;
            shift      <= '0;
            inst_o     <= '0;
            mem_req_o  <= MEM_REQ_DISABLE;
            mem_addr_o <= '0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (start) begin
                        state      <= FETCH_BUSY;
                        fetch_tag  <= pc_i[ADDR_W-1:2];
                        mem_addr_o <= {pc_i[ADDR_W-1:2], 2'b00};
                        buf_valid  <= 1'b0;
                        beat       <= 2'd0;
                        abort      <= 1'b0;
                        mem_req_o  <= MEM_REQ_ENABLE;
                    end
                end

                FETCH_BUSY: begin
                    if (flush_i) begin
                        abort <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        case (beat)
                            2'd0:    shift[7:0]   <= mem_data_i;
                            2'd1:    shift[15:8]  <= mem_data_i;
                            2'd2:    shift[23:16] <= mem_data_i;
                            default: ;
                        endcase

                        // A flushed fetch ends at the beat in flight rather than beat 3.
                        if (beat == 2'd3 || kill) begin
                            state     <= FETCH_IDLE;
                            mem_req_o <= MEM_REQ_DISABLE;
                            abort     <= 1'b0;
                            beat      <= 2'd0;
                            if (!kill) begin
                                inst_o    <= {mem_data_i, shift};
                                buf_tag   <= fetch_tag;
                                buf_valid <= 1'b1;
                            end
                        end else begin
                            beat       <= beat + 2'd1;
                            mem_addr_o <= {fetch_tag, beat + 2'd1};
                        end
                    end
                end

                default: state <= FETCH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Self-checking bench for inst_fetch_port: directed sequences, a combinational
// vector table against a filled buffer, and random fetches against a word-level model.
module tb_inst_fetch_port;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc_i;
    logic              ce_i;
    logic              flush_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_data_i;
    logic              mem_ack_i;
    logic [31:0]       inst_o;
    logic              inst_valid_o;
    logic              stallreq_o;

    inst_fetch_port #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-addressed backing memory; unwritten locations return a hash of the address.
    logic [7:0] mem [int unsigned];

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'((a * 37) ^ (a >> 7) ^ 32'h5A);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {mem_rd(b + 3), mem_rd(b + 2), mem_rd(b + 1), mem_rd(b)};
    endfunction

    // Memory responder: acks each beat after wait_cycles idle cycles.
    int wait_cycles = 0;
    bit stray_ack   = 1'b0;

    initial begin
        int wcnt;
        bit was_ack;
        wcnt       = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            was_ack    = mem_ack_i;
            mem_ack_i  = 1'b0;
            mem_data_i = 8'h00;
            if (was_ack || !rst) wcnt = 0;
            if (rst && mem_req_o) begin
                if (wcnt >= wait_cycles) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_rd(mem_addr_o);
                end else begin
                    wcnt++;
                end
            end else if (rst && stray_ack) begin
                mem_ack_i  = 1'b1;
                mem_data_i = 8'hEE;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int bound, output int n);
        n = 0;
        while (!inst_valid_o && n < bound) begin
            next();
            mid();
            n++;
        end
        check(name, inst_valid_o, 1'b1);
    endtask

    // Word-level reference: one buffered tag, words read straight from mem.
    bit          mdl_valid;
    logic [29:0] mdl_tag;

    task automatic do_fetch(input logic [31:0] pc, input int w, input bit fl, input bit perturb);
        bit exp_hit;
        int n;
        wait_cycles = w;
        next();
        pc_i    = pc;
        ce_i    = 1'b1;
        flush_i = fl;
        mid();
        exp_hit = mdl_valid && (pc[31:2] == mdl_tag);
        check("rnd_valid", inst_valid_o, exp_hit);
        check("rnd_stall", stallreq_o, !exp_hit && !fl);
        if (exp_hit) begin
            check("rnd_hit_word", inst_o, word_at(pc));
            check("rnd_hit_req", mem_req_o, 1'b0);
            flush_i = 1'b0;
        end else begin
            if (fl) begin
                next();
                flush_i = 1'b0;
                mid();
                check("rnd_flush_idle_req", mem_req_o, 1'b0);
                check("rnd_flush_idle_stall", stallreq_o, 1'b1);
            end
            n = 0;
            while (!inst_valid_o && n < 100) begin
                next();
                if (perturb && n == 0) begin
                    ce_i = 1'b0;
                    pc_i = pc ^ 32'h40;
                end else begin
                    ce_i = 1'b1;
                    pc_i = pc;
                end
                mid();
                n++;
            end
            check("rnd_latency", n, 1 + 4 * (w + 1));
            check("rnd_miss_word", inst_o, word_at(pc));
            check("rnd_miss_stall", stallreq_o, 1'b0);
            mdl_valid = 1'b1;
            mdl_tag   = pc[31:2];
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        flush;
        logic        exp_valid;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n;
        int beats;
        logic [31:0] pool[6];

        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int beats;
        logic [31:0] pool[6];

        vecs[0] = '{32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0101, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0103, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0104, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_0104, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_00FC, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h0000_0104, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'h0001_0100, 1'b1, 1'b0, 1'b0, 1'b1};

        mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h10; mem[32'h103] = 8'h00;
        mem[32'h204] = 8'hB7; mem[32'h205] = 8'h02; mem[32'h206] = 8'h00; mem[32'h207] = 8'h80;

        // Reset state, with a fetch request already pending on the inputs.
        rst = 1'b0; ce_i = 1'b1; pc_i = 32'h0; flush_i = 1'b0;
        repeat (2) mid();
        check("rst_inst", inst_o, 32'h0);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_valid", inst_valid_o, 1'b0);
        check("rst_stall", stallreq_o, 1'b0);
        next();
        ce_i = 1'b0;
        rst  = 1'b1;

        // Cold miss at 0x100 with zero-wait memory.
        next();
        pc_i = 32'h100; ce_i = 1'b1;
        mid();
        check("cold_t0_stall", stallreq_o, 1'b1);
        check("cold_t0_req", mem_req_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            next();
            mid();
            check("cold_stall", stallreq_o, 1'b1);
            check("cold_req", mem_req_o, 1'b1);
            check("cold_addr", mem_addr_o, 32'h100 + k);
        end
        next();
        mid();
        check("cold_valid", inst_valid_o, 1'b1);
        check("cold_word", inst_o, 32'h0010_0513);
        check("cold_t5_stall", stallreq_o, 1'b0);
        check("cold_t5_req", mem_req_o, 1'b0);

        // Hold the PC: repeated hits, with stray acks that must be ignored.
        stray_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next();
            mid();
            check("hit_valid", inst_valid_o, 1'b1);
            check("hit_req", mem_req_o, 1'b0);
            check("hit_stall", stallreq_o, 1'b0);
            check("hit_word", inst_o, 32'h0010_0513);
        end
        stray_ack = 1'b0;

        // Combinational vectors against a buffer holding 0x100; inputs restored before each edge.
        for (int i = 0; i < 9; i++) begin
            next();
            pc_i = vecs[i].pc; ce_i = vecs[i].ce; flush_i = vecs[i].flush;
            mid();
            check($sformatf("vec%0d_valid", i), inst_valid_o, vecs[i].exp_valid);
            check($sformatf("vec%0d_stall", i), stallreq_o, vecs[i].exp_stall);
            check($sformatf("vec%0d_req", i), mem_req_o, 1'b0);
            check($sformatf("vec%0d_word", i), inst_o, 32'h0010_0513);
            #1;
            pc_i = 32'h100; ce_i = 1'b1; flush_i = 1'b0;
        end

        // Two wait cycles before each ack; address must hold through every wait.
        wait_cycles = 2;
        stray_ack   = 1'b1;
        next();
        pc_i = 32'h204;
        mid();
        n = 0;
        beats = 0;
        while (!inst_valid_o && n < 40) begin
            next();
            mid();
            n++;
            if (mem_req_o) check("ws_addr", mem_addr_o, 32'h204 + beats);
            if (mem_req_o && mem_ack_i) beats++;
        end
        check("ws_latency", n, 13);
        check("ws_word", inst_o, 32'h8000_02B7);
        stray_ack = 1'b0;

        // Flush pulse while beat 1 of a fetch to 0x300 is waiting.
        next();
        pc_i = 32'h300;
        mid();
        for (int t = 1; t <= 8; t++) begin
            next();
            flush_i = (t == 4);
            mid();
            if (t == 6) begin
                check("fl1_t6_req", mem_req_o, 1'b1);
                check("fl1_t6_addr", mem_addr_o, 32'h301);
            end
            if (t == 7) begin
                check("fl1_t7_req", mem_req_o, 1'b0);
                check("fl1_t7_valid", inst_valid_o, 1'b0);
                check("fl1_t7_stall", stallreq_o, 1'b1);
                check("fl1_t7_word", inst_o, 32'h8000_02B7);
            end
            if (t == 8) begin
                check("fl1_t8_req", mem_req_o, 1'b1);
                check("fl1_t8_addr", mem_addr_o, 32'h300);
            end
        end
        wait_valid("fl1_refetch_done", 40, n);
        check("fl1_word", inst_o, word_at(32'h300));

        // Flush coincident with the final ack of a fetch to 0x400.
        wait_cycles = 0;
        next();
        pc_i = 32'h400;
        mid();
        for (int t = 1; t <= 5; t++) begin
            next();
            flush_i = (t == 4);
            mid();
            if (t == 4) begin
                check("fl2_t4_req", mem_req_o, 1'b1);
                check("fl2_t4_addr", mem_addr_o, 32'h403);
            end
            if (t == 5) begin
                check("fl2_valid", inst_valid_o, 1'b0);
                check("fl2_stall", stallreq_o, 1'b1);
                check("fl2_req", mem_req_o, 1'b0);
                check("fl2_word_kept", inst_o, word_at(32'h300));
            end
        end
        wait_valid("fl2_refetch_done", 20, n);
        check("fl2_word", inst_o, word_at(32'h400));

        // Unaligned PC fetches the containing word; the aligned PC then hits.
        next();
        pc_i = 32'h102;
        mid();
        check("ua_stall", stallreq_o, 1'b1);
        next();
        mid();
        check("ua_addr", mem_addr_o, 32'h100);
        wait_valid("ua_done", 20, n);
        check("ua_word", inst_o, 32'h0010_0513);
        next();
        pc_i = 32'h100;
        mid();
        check("ua_hit_valid", inst_valid_o, 1'b1);
        check("ua_hit_stall", stallreq_o, 1'b0);

        // Reset asserted in the middle of a fetch.
        next();
        pc_i = 32'h500;
        mid();
        next();
        mid();
        check("mrst_pre_req", mem_req_o, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("mrst_req", mem_req_o, 1'b0);
        check("mrst_valid", inst_valid_o, 1'b0);
        check("mrst_stall", stallreq_o, 1'b0);
        check("mrst_inst", inst_o, 32'h0);
        check("mrst_addr", mem_addr_o, 32'h0);
        next();
        pc_i = 32'h0;
        #2;
        rst = 1'b1;
        mid();
        check("mrst_pc0_stall", stallreq_o, 1'b1);
        check("mrst_pc0_valid", inst_valid_o, 1'b0);
        wait_valid("mrst_pc0_done", 20, n);
        check("mrst_pc0_word", inst_o, word_at(32'h0));
        mdl_valid = 1'b1;
        mdl_tag   = 30'h0;

        // Random fetches against the word-level model.
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h204;
        pool[3] = 32'h300; pool[4] = 32'h600; pool[5] = 32'h604;
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                next();
                ce_i = 1'b0;
                flush_i = 1'b0;
                mid();
                check("rnd_off_valid", inst_valid_o, 1'b0);
                check("rnd_off_stall", stallreq_o, 1'b0);
                check("rnd_off_req", mem_req_o, 1'b0);
            end else begin
                do_fetch(pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)),
                         $urandom_range(0, 2), r == 2, r == 3);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
